// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/result handshake bundle for the iterative divider
interface div_unit_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_dividend;
  logic [31:0]      in_divisor;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_dividend, in_divisor, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_dividend, in_divisor, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring divider for DIV/DIVU/REM/REMU with shared cla
module cla (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);
  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  // 4-bit lookahead groups; group carries chain between groups
  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c    = '0;
    c[0] = cin_i;
    for (int k = 0; k < 8; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end

  assign sum_o  = p ^ c[31:0];
  assign cout_o = c[32];
endmodule

module div_unit #(
  parameter int TAG_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  div_unit_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      quot_q, quot_d;
  logic [31:0]      dvsr_q, dvsr_d;
  logic [1:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      result_q, result_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;

  logic        accept;
  logic        signed_op;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, sovf;
  logic [31:0] fast_res;

  logic [32:0] rem_sh;
  logic [31:0] diff;
  logic        cout;
  logic        ge;
  logic [31:0] rem_nx, quot_nx;
  logic [31:0] q_fin, r_fin, res_fin;

  assign bus.in_ready   = (state_q == IDLE) & ~rst & ~flush;
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_result = result_q;
  assign bus.out_tag    = tag_q;

  assign accept    = bus.in_valid & bus.in_ready;
  assign signed_op = ~bus.in_op[0];
  assign a_neg     = signed_op & bus.in_dividend[31];
  assign b_neg     = signed_op & bus.in_divisor[31];
  assign a_mag     = a_neg ? (32'd0 - bus.in_dividend) : bus.in_dividend;
  assign b_mag     = b_neg ? (32'd0 - bus.in_divisor) : bus.in_divisor;
  assign div_zero  = (bus.in_divisor == 32'd0);
  assign sovf      = signed_op & (bus.in_dividend == 32'h8000_0000) & (bus.in_divisor == 32'hFFFF_FFFF);

  // Results that skip the iteration entirely: divide-by-zero and INT_MIN / -1
  always_comb begin
    fast_res = 32'd0;
    if (div_zero) begin
      fast_res = bus.in_op[1] ? bus.in_dividend : 32'hFFFF_FFFF;
    end else if (sovf) begin
      fast_res = bus.in_op[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One restoring step: 33-bit shifted remainder against the zero-extended divisor
  assign rem_sh = {rem_q, quot_q[31]};

  cla u_cla (
    .a_i    (rem_sh[31:0]),
    .b_i    (~dvsr_q),
    .cin_i  (1'b1),
    .sum_o  (diff),
    .cout_o (cout)
  );

  assign ge      = rem_sh[32] | cout;
  assign rem_nx  = ge ? diff : rem_sh[31:0];
  assign quot_nx = {quot_q[30:0], ge};
  assign q_fin   = neg_quot_q ? (32'd0 - quot_nx) : quot_nx;
  assign r_fin   = neg_rem_q ? (32'd0 - rem_nx) : rem_nx;
  assign res_fin = op_q[1] ? r_fin : q_fin;

  // Next-state logic: accept, iterate 32 times, hold result; flush wins over everything
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    op_d       = op_q;
    tag_d      = tag_q;
    result_d   = result_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = bus.in_op;
          tag_d = bus.in_tag;
          cnt_d = 5'd0;
          if (div_zero || sovf) begin
            result_d = fast_res;
            state_d  = DONE;
          end else begin
            rem_d      = 32'd0;
            quot_d     = a_mag;
            dvsr_d     = b_mag;
            neg_quot_d = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
            state_d    = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d  = rem_nx;
        quot_d = quot_nx;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = res_fin;
          cnt_d    = 5'd0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
    end
  end

  // State registers; reset also clears the visible result and tag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      rem_q      <= 32'd0;
      quot_q     <= 32'd0;
      dvsr_q     <= 32'd0;
      op_q       <= 2'd0;
      tag_q      <= '0;
      result_q   <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvsr_q     <= dvsr_d;
      op_q       <= op_d;
      tag_q      <= tag_d;
      result_q   <= result_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit
module tb_div_unit;
  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;
  logic [36:0] sb[$];

  div_unit_if #(.TAG_W(5)) bus ();

  div_unit #(.TAG_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sbv;
    sa  = a;
    sbv = b;
    case (op)
      2'b00: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sbv;
      end
      2'b01: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sbv;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Scoreboard: pop the oldest expectation whenever a result is handed off
  always @(negedge clk) begin
    logic [36:0] e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("result", 64'(bus.out_result), 64'(e[31:0]));
        check("tag", 64'(bus.out_tag), 64'(e[36:32]));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output int lat);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_op       = op;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    bus.in_tag      = tag;
    check("in_ready_at_issue", 64'(bus.in_ready), 64'd1);
    sb.push_back({tag, ref_res(op, a, b)});
    lat = ref_lat(op, a, b);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int lat);
    int n;
    n = 1;
    @(negedge clk);
    while (!bus.out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(lat));
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    int lat;
    issue(op, a, b, tag, lat);
    wait_out(lat);
  endtask

  initial begin
    int lat;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op = 2'b00;
    bus.in_dividend = 32'd0;
    bus.in_divisor = 32'd0;
    bus.in_tag = 5'd0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_ready_in_rst", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_result", 64'(bus.out_result), 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    run(2'b01, 32'd100, 32'd7, 5'd3);
    run(2'b11, 32'd100, 32'd7, 5'd4);
    run(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5);
    run(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6);
    run(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd7);
    run(2'b01, 32'd5, 32'd0, 5'd8);
    run(2'b10, 32'd5, 32'd0, 5'd9);
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd12);

    // Backpressure: result held five cycles with out_ready low
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    issue(2'b01, 32'd1000, 32'd7, 5'd13, lat);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_result", 64'(bus.out_result), 64'd142);
      check("bp_tag", 64'(bus.out_tag), 64'd13);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_hs", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_in_ready", 64'(bus.in_ready), 64'd1);
    check("bp_idle_valid", 64'(bus.out_valid), 64'd0);

    // Flush at T+10 during BUSY, then a fresh request at T+11
    issue(2'b01, 32'd123456, 32'd11, 5'd14, lat);
    void'(sb.pop_back());
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(bus.in_ready), 64'd0);
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    run(2'b01, 32'd9, 32'd3, 5'd15);

    // Reset at T+20 mid-operation
    issue(2'b00, 32'hDEAD_BEEF, 32'd77, 5'd16, lat);
    void'(sb.pop_back());
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mrst_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_result", 64'(bus.out_result), 64'd0);
    check("mrst_tag", 64'(bus.out_tag), 64'd0);
    check("mrst_in_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 24; i++) begin
      run(2'($urandom_range(0, 3)), pick(), pick(), 5'(i));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("end_valid", 64'(bus.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Multi-cycle iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits alongside the execute-stage ALU and feeds its trial subtraction through a single instance of the team's 32-bit carry-lookahead adder, cla, one quotient bit per cycle. The execute stage hands over operands through a valid/ready handshake. Results return through a second valid/ready handshake to the writeback mux, tagged with the destination register.

Parameters:
TAG_W, 5, width of the opaque tag (destination register index) carried from request to result.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  abort any in-flight or completed operation (branch mispredict)
in_valid  input  1  request valid
in_ready  output  1  block can accept a request this cycle
in_dividend  input  32  rs1 value
in_divisor  input  32  rs2 value
in_op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
in_tag  input  TAG_W  passed through unchanged
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  32  quotient or remainder per in_op
out_tag  output  TAG_W  tag of the request producing out_result

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- States: IDLE, BUSY, DONE.
- Reset: state IDLE; out_valid 0; out_result 0; out_tag 0; iteration counter 0.
- in_ready = (state==IDLE) & ~rst & ~flush. Accept occurs on in_valid & in_ready; call that cycle T.
- On accept, latch op, tag, |dividend|, |divisor|, and sign info. Signed ops (00, 10) take two's-complement magnitudes. Unsigned ops take raw values.
- Fast path, divisor==0:
  - Result is 0xFFFFFFFF for DIV/DIVU and the dividend for REM/REMU.
  - state goes to DONE; out_valid is high at T+1.
- Fast path, signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF):
  - Quotient 0x80000000, remainder 0.
  - DONE at T+1.
- Normal path: BUSY for exactly 32 cycles (T+1..T+32). Each cycle:
  - Shift {rem, quot} left by 1, bringing in the next dividend MSB.
  - Trial difference = shifted rem − divisor, low 32 bits from cla with a=rem_shifted[31:0], b=~divisor, cin=1.
  - Accept the difference iff the 33-bit shifted remainder >= the zero-extended divisor (unsigned). On accept, rem takes the difference and the quotient LSB is 1; otherwise rem is kept and the quotient LSB is 0.
- After the 32nd iteration, apply signs:
  - Quotient is negated iff the operand signs differ (signed ops only).
  - Remainder takes the dividend's sign.
- DONE is entered with out_valid high at T+33.
- DONE holds until out_ready.
  - out_result and out_tag stay stable while out_valid & ~out_ready.
  - On out_valid & out_ready, go to IDLE next cycle. in_ready is not asserted in the handshake cycle (no back-to-back bypass).
- flush (any state): next state IDLE, out_valid 0 next cycle, counter cleared; the pending result is discarded. flush overrides in_valid and out_ready in the same cycle.
- rst mid-operation behaves as flush plus clearing out_result/out_tag to 0.
- Exactly one result per accepted request unless flushed or reset. No result without a request.

Test Plan:
- DIVU 100/7 → out_result 14 at T+33; REMU 100/7 → 2; out_tag equals in_tag.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3); REM same operands → 0xFFFFFFFF (−1); REM 7/−2 → 1.
- DIVU 5/0 → 0xFFFFFFFF at T+1; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 at T+1; REM same operands → 0.
- Backpressure: hold out_ready low 5 cycles after out_valid. Required: out_result/out_tag constant, in_ready 0 throughout, IDLE one cycle after out_ready.
- flush at T+10 during BUSY: out_valid never rises for that request; in_ready=1 at T+11; a new DIVU 9/3 accepted at T+11 → 3 at T+44.
- rst asserted at T+20: all outputs 0 the next cycle, in_ready 1 the cycle after rst deasserts; random DIV/DIVU/REM/REMU (including 0 and 0x80000000 operands) match a reference model.
